// File: rtl/rt_lim_if.sv
// Core-side data-memory bus of the racetrack LiM controller: req/gnt request
// channel plus the one-cycle rvalid response channel.
interface rt_lim_if;
   logic        data_req_i;
   logic        data_gnt_o;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic [2:0]  data_lim_op_i;
   logic [31:0] data_mask_i;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;

   modport slave (
      input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
             data_lim_op_i, data_mask_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );

   modport master (
      output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
             data_lim_op_i, data_mask_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );
endinterface

// File: rtl/rt_lim_ctrl.sv
// Racetrack LiM data-memory access controller: one outstanding core request,
// word-line decode, racetrack handshake with timeout, single-pulse response.
module rt_lim_wl_lane #(
   parameter int IW   = 8,
   parameter int LANE = 0
) (
   input  logic          issue_i,
   input  logic [IW-1:0] widx_i,
   input  logic [3:0]    bits_i,
   output logic [3:0]    wl_o
);
   assign wl_o = (issue_i && (widx_i == IW'(LANE))) ? bits_i : 4'h0;
endmodule

module rt_lim_ctrl #(
   parameter int          ADDR_WIDTH = 10,
   parameter int          BYTES      = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
   parameter int          TIMEOUT    = 16,
   parameter logic [2:0]  FUNCT_AND  = 3'b001,
   parameter logic [2:0]  FUNCT_OR   = 3'b010,
   parameter logic [2:0]  FUNCT_XOR  = 3'b011
) (
   input  logic             clk_i,
   input  logic             rst_i,
   rt_lim_if.slave          core_if,
   output logic             en_b_int_o,
   output logic             we_b_o,
   output logic [BYTES-1:0] word_lines_o,
   output logic [2:0]       opcode_mem_o,
   output logic [31:0]      mask_o,
   output logic [31:0]      wdata_b_o,
   input  logic [31:0]      rdata_b_i,
   input  logic             rvalid_rt_i
);
   localparam int NW = BYTES / 4;
   localparam int IW = ADDR_WIDTH - 2;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_INIT = CW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic [32:0] LO_A = {1'b0, BASE_ADDR};
   localparam logic [32:0] HI_A = LO_A + 33'(BYTES);

   typedef struct packed {
      logic          we;
      logic          lim;
      logic [3:0]    be;
      logic [31:0]   wdata;
      logic [2:0]    op;
      logic [31:0]   mask;
      logic [IW-1:0] widx;
   } req_t;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   req_t          req_q, req_d;

   logic          in_range, latch, issue, resp, is_lim;
   logic [32:0]   addr_x;
   logic [3:0]    wl_bits;
   logic          unused_addr;

   assign addr_x      = {1'b0, core_if.data_addr_i};
   assign in_range    = (addr_x >= LO_A) && (addr_x < HI_A);
   assign unused_addr = ^core_if.data_addr_i[1:0];
   assign is_lim      = (core_if.data_lim_op_i == FUNCT_AND) ||
                        (core_if.data_lim_op_i == FUNCT_OR)  ||
                        (core_if.data_lim_op_i == FUNCT_XOR);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      latch   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (core_if.data_req_i) begin
               latch = 1'b1;
               if (in_range) begin
                  state_d = S_ISSUE;
                  cnt_d   = TO_INIT;
                  err_d   = 1'b0;
               end else begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            // completion wins over an expiring counter in the same cycle
            if (rvalid_rt_i) begin
               state_d = S_RESP;
               err_d   = 1'b0;
            end else if (cnt_q == '0) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_d = req_q;
      if (latch) begin
         req_d.we    = core_if.data_we_i;
         req_d.lim   = is_lim;
         req_d.be    = core_if.data_be_i;
         req_d.wdata = core_if.data_wdata_i;
         req_d.op    = core_if.data_lim_op_i;
         req_d.mask  = core_if.data_mask_i;
         req_d.widx  = core_if.data_addr_i[ADDR_WIDTH-1:2];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         req_q   <= req_d;
      end
   end

   assign issue = (state_q == S_ISSUE);
   assign resp  = (state_q == S_RESP);

   // reset gates the combinational grant so every output reads 0 under reset
   assign core_if.data_gnt_o    = (state_q == S_IDLE) && core_if.data_req_i && !rst_i;
   assign core_if.data_rvalid_o = resp;
   assign core_if.data_err_o    = resp && err_q;
   assign core_if.data_rdata_o  = (resp && !err_q && !req_q.we) ? rdata_b_i : 32'h0;

   // dropping the enable in RESP sends the racetrack to idle, not port-set
   assign en_b_int_o   = issue;
   assign we_b_o       = issue && req_q.we;
   assign opcode_mem_o = issue ? req_q.op    : 3'h0;
   assign mask_o       = issue ? req_q.mask  : 32'h0;
   assign wdata_b_o    = issue ? req_q.wdata : 32'h0;

   // only plain stores honour byte enables; loads and LiM ops touch the word
   assign wl_bits = (req_q.we && !req_q.lim) ? req_q.be : 4'hF;

   logic [NW-1:0][3:0] wl_lane;

   genvar g;
   for (g = 0; g < NW; g++) begin : g_lane
      rt_lim_wl_lane #(.IW(IW), .LANE(g)) u_lane (
         .issue_i (issue),
         .widx_i  (req_q.widx),
         .bits_i  (wl_bits),
         .wl_o    (wl_lane[g])
      );
   end

   assign word_lines_o = wl_lane;
endmodule

// File: tb/tb_rt_lim_ctrl.sv
// Directed bench for rt_lim_ctrl: behavioural racetrack model plus a
// response scoreboard checked by an independent monitor.
module tb_rt_lim_ctrl;
   localparam int          AW    = 10;
   localparam int          BYTES = 1024;
   localparam logic [31:0] BASE  = 32'h0010_0000;
   localparam int          TO    = 16;
   localparam logic [2:0]  F_AND = 3'b001;
   localparam logic [2:0]  F_OR  = 3'b010;
   localparam logic [2:0]  F_XOR = 3'b011;
   localparam logic [2:0]  PLAIN = 3'b000;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             en_b_int, we_b, rvalid_rt;
   logic [BYTES-1:0] word_lines;
   logic [2:0]       opcode_mem;
   logic [31:0]      mask_b, wdata_b, rdata_b;

   rt_lim_if bus ();

   rt_lim_ctrl #(
      .ADDR_WIDTH(AW), .BYTES(BYTES), .BASE_ADDR(BASE), .TIMEOUT(TO),
      .FUNCT_AND(F_AND), .FUNCT_OR(F_OR), .FUNCT_XOR(F_XOR)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .core_if      (bus),
      .en_b_int_o   (en_b_int),
      .we_b_o       (we_b),
      .word_lines_o (word_lines),
      .opcode_mem_o (opcode_mem),
      .mask_o       (mask_b),
      .wdata_b_o    (wdata_b),
      .rdata_b_i    (rdata_b),
      .rvalid_rt_i  (rvalid_rt)
   );

   always #5 clk_i = ~clk_i;

   // racetrack model: completes a plain access on its 3rd enabled cycle and a
   // LiM access on its 6th; rdata is registered one cycle after rvalid
   logic [7:0] mem [BYTES];
   int         rt_cnt;
   bit         rt_dead;

   function automatic bit lim_op(input logic [2:0] op);
      return (op == F_AND) || (op == F_OR) || (op == F_XOR);
   endfunction

   function automatic logic [7:0] lop(input logic [2:0] op, input logic [7:0] a, input logic [7:0] m);
      if (op == F_AND) return a & m;
      if (op == F_OR)  return a | m;
      return a ^ m;
   endfunction

   function automatic logic [31:0] rd_word(input logic [BYTES-1:0] wl);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < BYTES; i++)
         if (wl[i]) r[8*(i%4) +: 8] = mem[i];
      return r;
   endfunction

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rt_cnt    <= 0;
         rvalid_rt <= 1'b0;
         rdata_b   <= '0;
      end else if (rvalid_rt) begin
         rvalid_rt <= 1'b0;
         rt_cnt    <= 0;
         rdata_b   <= rd_word(word_lines);
         if (we_b)
            for (int i = 0; i < BYTES; i++)
               if (word_lines[i])
                  mem[i] <= lim_op(opcode_mem) ? lop(opcode_mem, mem[i], mask_b[8*(i%4) +: 8])
                                               : wdata_b[8*(i%4) +: 8];
      end else if (en_b_int) begin
         if (!rt_dead && rt_cnt == (lim_op(opcode_mem) ? 4 : 1)) rvalid_rt <= 1'b1;
         rt_cnt <= rt_cnt + 1;
      end else begin
         rt_cnt <= 0;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   // monitor: samples mid-low-phase, after stimulus has settled
   int cyc = 0;
   int gcyc = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         cyc++;
         if (bus.data_req_i && bus.data_gnt_o) gcyc = cyc;
         if (bus.data_rvalid_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_rvalid", 32'(bus.data_rvalid_o), 32'h0);
            end else begin
               e = sb.pop_front();
               chk("rdata", bus.data_rdata_o, e.rdata);
               chk("err", 32'(bus.data_err_o), 32'(e.err));
               chk("latency", 32'(cyc - gcyc), 32'(e.lat));
            end
         end
      end
   end

   task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [2:0] op, input logic [31:0] mk,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int exp_en, input int wl_base, input logic [3:0] wl_exp);
      exp_t             e;
      int               n;
      logic [BYTES-1:0] wl_s;
      @(negedge clk_i);
      bus.data_addr_i   = addr;
      bus.data_we_i     = we;
      bus.data_be_i     = be;
      bus.data_wdata_i  = wd;
      bus.data_lim_op_i = op;
      bus.data_mask_i   = mk;
      bus.data_req_i    = 1'b1;
      #1;
      n = 0;
      while (!bus.data_gnt_o && n < 20) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      chk("gnt", 32'(bus.data_gnt_o), 32'h1);
      e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
      sb.push_back(e);
      @(posedge clk_i);
      #1;
      bus.data_req_i = 1'b0;
      @(negedge clk_i);
      chk("wl_count", 32'($countones(word_lines)), (exp_en > 0) ? 32'($countones(wl_exp)) : 32'h0);
      if (exp_en > 0) begin
         wl_s = word_lines >> wl_base;
         chk("wl_slice", 32'(wl_s[3:0]), 32'(wl_exp));
      end
      n = 0;
      while (en_b_int && n < 40) begin
         n++;
         @(negedge clk_i);
      end
      chk("en_cycles", 32'(n), 32'(exp_en));
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk("resp_seen", 32'(sb.size()), 32'h0);
      sb.delete();
   endtask

   initial begin
      rst_i             = 1'b1;
      rt_dead           = 1'b0;
      bus.data_req_i    = 1'b0;
      bus.data_addr_i   = '0;
      bus.data_we_i     = 1'b0;
      bus.data_be_i     = '0;
      bus.data_wdata_i  = '0;
      bus.data_lim_op_i = '0;
      bus.data_mask_i   = '0;
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_ctl", {25'h0, en_b_int, we_b, bus.data_rvalid_o, bus.data_err_o,
                      bus.data_gnt_o, 2'b00}, 32'h0);
      chk("rst_wl", 32'($countones(word_lines)), 32'h0);
      chk("rst_bus", bus.data_rdata_o | mask_b | wdata_b | 32'(opcode_mem), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // full-word store / load
      issue(BASE + 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, PLAIN, 32'h0, 32'h0, 1'b0, 4, 3, 16, 4'hF);
      issue(BASE + 32'h10, 1'b0, 4'h0, 32'h0, PLAIN, 32'h0, 32'hDEADBEEF, 1'b0, 4, 3, 16, 4'hF);
      // byte store; load with low address bits set
      issue(BASE + 32'h10, 1'b1, 4'b0010, 32'h0000AA00, PLAIN, 32'h0, 32'h0, 1'b0, 4, 3, 16, 4'b0010);
      issue(BASE + 32'h13, 1'b0, 4'h0, 32'h0, PLAIN, 32'h0, 32'hDEADAAEF, 1'b0, 4, 3, 16, 4'hF);
      // LiM AND store: byte enables ignored, long racetrack wait
      issue(BASE + 32'h10, 1'b1, 4'b0001, 32'h0, F_AND, 32'h0F0F0F0F, 32'h0, 1'b0, 7, 6, 16, 4'hF);
      issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, PLAIN, 32'h0, 32'h0E0D0A0F, 1'b0, 4, 3, 16, 4'hF);
      // last word of the array
      issue(BASE + 32'h3FC, 1'b1, 4'hF, 32'h12345678, PLAIN, 32'h0, 32'h0, 1'b0, 4, 3, 1020, 4'hF);
      issue(BASE + 32'h3FC, 1'b0, 4'hF, 32'h0, PLAIN, 32'h0, 32'h12345678, 1'b0, 4, 3, 1020, 4'hF);
      // out of range on either side
      issue(BASE + 32'h400, 1'b0, 4'hF, 32'h0, PLAIN, 32'h0, 32'h0, 1'b1, 1, 0, 0, 4'h0);
      issue(BASE - 32'h4, 1'b1, 4'hF, 32'h55, PLAIN, 32'h0, 32'h0, 1'b1, 1, 0, 0, 4'h0);
      // racetrack silent: timeout
      rt_dead = 1'b1;
      issue(BASE + 32'h20, 1'b0, 4'hF, 32'h0, PLAIN, 32'h0, 32'h0, 1'b1, TO + 1, TO, 32, 4'hF);
      rt_dead = 1'b0;
      issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, PLAIN, 32'h0, 32'h0E0D0A0F, 1'b0, 4, 3, 16, 4'hF);

      // reset while in ISSUE drops the request
      @(negedge clk_i);
      bus.data_addr_i   = BASE + 32'h10;
      bus.data_we_i     = 1'b0;
      bus.data_lim_op_i = PLAIN;
      bus.data_req_i    = 1'b1;
      @(posedge clk_i);
      #1;
      bus.data_req_i = 1'b0;
      @(negedge clk_i);
      #3;
      chk("pre_rst_en", 32'(en_b_int), 32'h1);
      rst_i = 1'b1;
      #1;
      chk("async_en", 32'(en_b_int), 32'h0);
      chk("async_wl", 32'($countones(word_lines)), 32'h0);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (6) @(negedge clk_i);
      issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, PLAIN, 32'h0, 32'h0E0D0A0F, 1'b0, 4, 3, 16, 4'hF);

      repeat (3) @(negedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
